// File: rtl/theta_lock_monitor.sv
// Observer of the two-layer theta predictor: scores L1 spike phase against the
// L2 prediction once per gamma cycle, keeps per-slot leaky error averages and lock status.
module theta_lock_monitor #(
    parameter logic [7:0] TOL        = 8'd4,
    parameter logic [7:0] UNLOCK_TOL = 8'd16,
    parameter logic [7:0] LOCK_CNT   = 8'd16,
    parameter logic [7:0] WARMUP_CYC = 8'd4,
    parameter int         AVG_SHIFT  = 3,
    parameter logic [7:0] MISS_ERR   = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        cycle_start,
    input  logic        fired_L1,
    input  logic [7:0]  phase_L1,
    input  logic [7:0]  pred_L2,
    input  logic [2:0]  theta_in,
    input  logic [2:0]  sel_slot,
    output logic        eval_valid,
    output logic [7:0]  err_last,
    output logic [7:0]  err_avg_sel,
    output logic [7:0]  streak,
    output logic [15:0] miss_cnt,
    output logic        locked,
    output logic        lock_pulse,
    output logic        unlock_pulse
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        cap_valid_reg, cap_valid_next;
    logic [7:0]  cap_phase_reg, cap_phase_next;
    logic [7:0]  warm_cnt_reg, warm_cnt_next;
    logic [7:0]  streak_next;
    logic [15:0] miss_cnt_next;
    logic [7:0]  err_last_next;
    logic        eval_valid_next;
    logic        lock_pulse_next;
    logic        unlock_pulse_next;

    logic [7:0]  avg_reg [8];
    logic [7:0]  avg_cur;
    logic [8:0]  avg_sum;
    logic [7:0]  avg_upd;

    logic        do_eval;
    logic [7:0]  err_now;
    logic        err_good;
    logic        err_drop;
    logic [7:0]  streak_inc;

    // Evaluation closes the cycle using the capture from before this edge.
    assign do_eval = en && cycle_start && (state_reg != S_IDLE);

    always_comb begin
        err_now = MISS_ERR;
        if (cap_valid_reg) begin
            if (cap_phase_reg >= pred_L2)
                err_now = cap_phase_reg - pred_L2;
            else
                err_now = pred_L2 - cap_phase_reg;
        end
    end

    assign err_good   = (err_now <= TOL);
    assign err_drop   = (err_now > UNLOCK_TOL);
    assign streak_inc = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;

    // Leaky average; the sum cannot exceed 255 but is clamped for any AVG_SHIFT.
    assign avg_cur = avg_reg[theta_in];
    assign avg_sum = {1'b0, avg_cur - (avg_cur >> AVG_SHIFT)} + {1'b0, err_now >> AVG_SHIFT};
    assign avg_upd = avg_sum[8] ? 8'hFF : avg_sum[7:0];

    // A spike on the cycle_start clock opens the new cycle's capture.
    always_comb begin
        cap_valid_next = cap_valid_reg;
        cap_phase_next = cap_phase_reg;
        if (!en) begin
            cap_valid_next = 1'b0;
        end else if (cycle_start) begin
            cap_valid_next = fired_L1;
            if (fired_L1)
                cap_phase_next = phase_L1;
        end else if (fired_L1 && !cap_valid_reg) begin
            cap_valid_next = 1'b1;
            cap_phase_next = phase_L1;
        end
    end

    always_comb begin
        state_next        = state_reg;
        warm_cnt_next     = warm_cnt_reg;
        streak_next       = streak;
        miss_cnt_next     = miss_cnt;
        err_last_next     = err_last;
        eval_valid_next   = 1'b0;
        lock_pulse_next   = 1'b0;
        unlock_pulse_next = 1'b0;

        if (!en) begin
            state_next    = S_IDLE;
            streak_next   = 8'd0;
            warm_cnt_next = 8'd0;
        end else if (state_reg == S_IDLE) begin
            state_next    = S_WARMUP;
            streak_next   = 8'd0;
            warm_cnt_next = 8'd0;
        end else if (cycle_start) begin
            eval_valid_next = 1'b1;
            err_last_next   = err_now;
            if (!cap_valid_reg && miss_cnt != 16'hFFFF)
                miss_cnt_next = miss_cnt + 16'd1;

            if (state_reg == S_WARMUP) begin
                streak_next = 8'd0;
                if (warm_cnt_reg + 8'd1 >= WARMUP_CYC) begin
                    state_next    = S_TRACK;
                    warm_cnt_next = 8'd0;
                end else begin
                    warm_cnt_next = warm_cnt_reg + 8'd1;
                end
            end else if (state_reg == S_TRACK) begin
                if (err_good) begin
                    streak_next = streak_inc;
                    if (streak_inc >= LOCK_CNT) begin
                        state_next      = S_LOCKED;
                        lock_pulse_next = 1'b1;
                    end
                end else begin
                    streak_next = 8'd0;
                end
            end else begin
                // LOCKED: moderate errors only clear the streak (hysteresis band).
                if (err_good) begin
                    streak_next = streak_inc;
                end else if (!err_drop) begin
                    streak_next = 8'd0;
                end else begin
                    streak_next       = 8'd0;
                    state_next        = S_TRACK;
                    unlock_pulse_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cap_valid_reg <= 1'b0;
            cap_phase_reg <= 8'd0;
            warm_cnt_reg  <= 8'd0;
            streak        <= 8'd0;
            miss_cnt      <= 16'd0;
            err_last      <= 8'd0;
            eval_valid    <= 1'b0;
            lock_pulse    <= 1'b0;
            unlock_pulse  <= 1'b0;
            locked        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cap_valid_reg <= cap_valid_next;
            cap_phase_reg <= cap_phase_next;
            warm_cnt_reg  <= warm_cnt_next;
            streak        <= streak_next;
            miss_cnt      <= miss_cnt_next;
            err_last      <= err_last_next;
            eval_valid    <= eval_valid_next;
            lock_pulse    <= lock_pulse_next;
            unlock_pulse  <= unlock_pulse_next;
            locked        <= (state_next == S_LOCKED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++)
                avg_reg[i] <= 8'hFF;
        end else if (do_eval) begin
            avg_reg[theta_in] <= avg_upd;
        end
    end

    // Readout sees the pre-update value when the selected slot is written this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_avg_sel <= 8'd0;
        else
            err_avg_sel <= avg_reg[sel_slot];
    end

endmodule

// File: tb/tb_theta_lock_monitor.sv
// Directed bench for theta_lock_monitor: reset, warmup/lock, hysteresis, miss,
// slot averages, cycle-boundary capture and enable drop.
module tb_theta_lock_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cycle_start;
    logic        fired_L1;
    logic [7:0]  phase_L1;
    logic [7:0]  pred_L2;
    logic [2:0]  theta_in;
    logic [2:0]  sel_slot;
    logic        eval_valid;
    logic [7:0]  err_last;
    logic [7:0]  err_avg_sel;
    logic [7:0]  streak;
    logic [15:0] miss_cnt;
    logic        locked;
    logic        lock_pulse;
    logic        unlock_pulse;

    int checks = 0;
    int errors = 0;

    theta_lock_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cycle_start  (cycle_start),
        .fired_L1     (fired_L1),
        .phase_L1     (phase_L1),
        .pred_L2      (pred_L2),
        .theta_in     (theta_in),
        .sel_slot     (sel_slot),
        .eval_valid   (eval_valid),
        .err_last     (err_last),
        .err_avg_sel  (err_avg_sel),
        .streak       (streak),
        .miss_cnt     (miss_cnt),
        .locked       (locked),
        .lock_pulse   (lock_pulse),
        .unlock_pulse (unlock_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One gamma cycle: optional spike early, then the closing cycle_start edge.
    task automatic close_cycle(input logic spike, input logic [7:0] ph,
                               input logic [7:0] pred, input logic [2:0] th);
        fired_L1 = spike;
        phase_L1 = ph;
        cycle_start = 1'b0;
        tick();
        fired_L1 = 1'b0;
        tick();
        tick();
        cycle_start = 1'b1;
        pred_L2 = pred;
        theta_in = th;
        tick();
        cycle_start = 1'b0;
        $display("cycle theta=%0d err=%0d streak=%0d locked=%0d miss=%0d",
                 th, err_last, streak, locked, miss_cnt);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cycle_start = 1'b0; fired_L1 = 1'b0;
        phase_L1 = 8'd0; pred_L2 = 8'd0; theta_in = 3'd0; sel_slot = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        // T1: reset values
        chk("rst_eval_valid", 32'(eval_valid), 0);
        chk("rst_err_last", 32'(err_last), 0);
        chk("rst_avg_sel", 32'(err_avg_sel), 0);
        chk("rst_streak", 32'(streak), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        chk("rst_locked", 32'(locked), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_avg_sel", 32'(err_avg_sel), 255);

        // T5: slot 0 average from reset
        en = 1'b1;
        tick();
        close_cycle(1'b1, 8'd1, 8'd1, 3'd0);
        chk("t5_eval_valid", 32'(eval_valid), 1);
        chk("t5_err0", 32'(err_last), 0);
        chk("t5_warm_streak", 32'(streak), 0);
        chk("t5_avg_lat", 32'(err_avg_sel), 255);
        tick();
        chk("t5_avg1", 32'(err_avg_sel), 224);
        chk("t5_eval_valid_low", 32'(eval_valid), 0);
        sel_slot = 3'd1;
        tick();
        chk("t5_slot1", 32'(err_avg_sel), 255);
        sel_slot = 3'd0;
        close_cycle(1'b1, 8'd1, 8'd1, 3'd0);
        tick();
        chk("t5_avg2", 32'(err_avg_sel), 196);

        // T2: two more warmup evals, then 16 good evals to lock
        close_cycle(1'b1, 8'd1, 8'd1, 3'd1);
        close_cycle(1'b1, 8'd1, 8'd1, 3'd2);
        chk("t2_warm_end_streak", 32'(streak), 0);
        chk("t2_warm_miss", 32'(miss_cnt), 0);
        for (int i = 1; i <= 16; i++) begin
            close_cycle(1'b1, 8'd1, 8'd1, 3'(1 + (i % 7)));
            chk("t2_streak", 32'(streak), 32'(i));
            chk("t2_lock_pulse", 32'(lock_pulse), (i == 16) ? 1 : 0);
            chk("t2_locked", 32'(locked), (i == 16) ? 1 : 0);
        end
        tick();
        chk("t2_pulse_clear", 32'(lock_pulse), 0);
        chk("t2_still_locked", 32'(locked), 1);

        // T3: hysteresis band then unlock
        close_cycle(1'b1, 8'd17, 8'd1, 3'd1);
        chk("t3_err16", 32'(err_last), 16);
        chk("t3_err16_streak", 32'(streak), 0);
        chk("t3_err16_locked", 32'(locked), 1);
        chk("t3_err16_unlock", 32'(unlock_pulse), 0);
        close_cycle(1'b1, 8'd1, 8'd11, 3'd2);
        chk("t3_err10_abs", 32'(err_last), 10);
        chk("t3_err10_locked", 32'(locked), 1);
        close_cycle(1'b1, 8'd2, 8'd1, 3'd3);
        chk("t3_regain_streak", 32'(streak), 1);
        close_cycle(1'b1, 8'd40, 8'd1, 3'd4);
        chk("t3_err39", 32'(err_last), 39);
        chk("t3_unlock_pulse", 32'(unlock_pulse), 1);
        chk("t3_unlocked", 32'(locked), 0);
        chk("t3_streak0", 32'(streak), 0);
        tick();
        chk("t3_unlock_clear", 32'(unlock_pulse), 0);

        // T4: tolerance edge and miss
        close_cycle(1'b1, 8'd6, 8'd1, 3'd5);
        chk("t4_err5_streak", 32'(streak), 0);
        close_cycle(1'b1, 8'd5, 8'd1, 3'd5);
        chk("t4_err4_streak", 32'(streak), 1);
        close_cycle(1'b0, 8'd0, 8'd1, 3'd6);
        chk("t4_miss_err", 32'(err_last), 255);
        chk("t4_miss_cnt", 32'(miss_cnt), 1);
        chk("t4_miss_streak", 32'(streak), 0);

        // T6: spike on the cycle_start clock belongs to the next cycle
        tick(); tick(); tick();
        cycle_start = 1'b1; fired_L1 = 1'b1; phase_L1 = 8'd7; pred_L2 = 8'd1; theta_in = 3'd2;
        tick();
        cycle_start = 1'b0; fired_L1 = 1'b0;
        chk("t6_boundary_miss", 32'(err_last), 255);
        chk("t6_boundary_misscnt", 32'(miss_cnt), 2);
        close_cycle(1'b0, 8'd0, 8'd7, 3'd3);
        chk("t6_carried_err", 32'(err_last), 0);
        chk("t6_carried_misscnt", 32'(miss_cnt), 2);
        chk("t6_carried_streak", 32'(streak), 1);
        fired_L1 = 1'b1; phase_L1 = 8'd3;
        tick();
        phase_L1 = 8'd50;
        tick();
        fired_L1 = 1'b0;
        tick();
        cycle_start = 1'b1; pred_L2 = 8'd3; theta_in = 3'd4;
        tick();
        cycle_start = 1'b0;
        chk("t6_first_spike_only", 32'(err_last), 0);
        chk("t6_first_spike_streak", 32'(streak), 2);

        for (int i = 3; i <= 16; i++) begin
            close_cycle(1'b1, 8'd9, 8'd9, 3'(1 + (i % 7)));
            chk("t6_relock_streak", 32'(streak), 32'(i));
        end
        chk("t6_relock_pulse", 32'(lock_pulse), 1);
        chk("t6_relocked", 32'(locked), 1);

        // en dropped while LOCKED
        en = 1'b0;
        tick();
        chk("t6_en_locked", 32'(locked), 0);
        chk("t6_en_streak", 32'(streak), 0);
        chk("t6_en_unlock", 32'(unlock_pulse), 0);
        chk("t6_en_miss_kept", 32'(miss_cnt), 2);
        chk("t6_en_err_kept", 32'(err_last), 0);
        chk("t6_en_avg_kept", 32'(err_avg_sel), 196);
        cycle_start = 1'b1;
        tick();
        cycle_start = 1'b0;
        chk("t6_en_no_eval", 32'(eval_valid), 0);
        en = 1'b1;
        tick();
        close_cycle(1'b1, 8'd1, 8'd1, 3'd1);
        chk("t6_reen_eval", 32'(eval_valid), 1);
        chk("t6_reen_warm_streak", 32'(streak), 0);
        chk("t6_reen_locked", 32'(locked), 0);

        // T1: reset mid-run acts immediately
        close_cycle(1'b0, 8'd0, 8'd1, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miss", 32'(miss_cnt), 0);
        chk("mid_rst_err", 32'(err_last), 0);
        chk("mid_rst_eval", 32'(eval_valid), 0);
        chk("mid_rst_avg_sel", 32'(err_avg_sel), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_avg_sel", 32'(err_avg_sel), 255);
        chk("mid_rel_pulses", 32'({lock_pulse, unlock_pulse}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
